// File: rtl/insn_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, its instruction memory and
// the decode stage.
//
// Signals
//   imem_addr       fetch -> imem    read address, latched by imem at posedge
//   imem_insn       imem  -> fetch   data for the address of the previous cycle
//   redirect_valid  core  -> fetch   flush and restart at redirect_pc
//   redirect_pc     core  -> fetch   redirect target
//   stall           decode -> fetch  decode not ready, hold the output entry
//   out_valid       fetch -> decode  out_insn/out_pc hold a valid entry
//   out_insn        fetch -> decode  fetched instruction
//   out_pc          fetch -> decode  PC of out_insn
//
// Modports: master = fetch unit side, slave = memory/decode/environment side.

`ifndef INSN_WIDTH
`define INSN_WIDTH 32
`endif
`ifndef INSN_ADDR_WIDTH
`define INSN_ADDR_WIDTH 32
`endif

interface insn_fetch_unit_if #(
  parameter int INSN_WIDTH = `INSN_WIDTH,
  parameter int ADDR_WIDTH = `INSN_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INSN_WIDTH-1:0] imem_insn;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  stall;
  logic                  out_valid;
  logic [INSN_WIDTH-1:0] out_insn;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_insn,
    input  redirect_valid,
    input  redirect_pc,
    input  stall,
    output out_valid,
    output out_insn,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_insn,
    output redirect_valid,
    output redirect_pc,
    output stall,
    input  out_valid,
    input  out_insn,
    input  out_pc
  );
endinterface

// File: rtl/insn_fetch_unit.sv
// Instruction fetch unit. Owns the PC, drives the synchronous-read
// instruction memory every cycle, tags each returned word with its PC in a
// 2-entry FIFO and presents the head to decode with valid/stall. A redirect
// flushes everything and issues the target in the same cycle.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   bus             insn_fetch_unit_if.master (imem_addr/imem_insn,
//                   redirect_valid/redirect_pc, stall,
//                   out_valid/out_insn/out_pc)
//   perf_fetch_cnt  (IFETCH_PERF_EN only) number of entries handed to decode
//   perf_stall_cnt  (IFETCH_PERF_EN only) cycles with out_valid & stall
//
// Configuration
//   IFETCH_PERF_EN  when defined, adds the two 32-bit performance counters.

`ifndef INSN_WIDTH
`define INSN_WIDTH 32
`endif
`ifndef INSN_ADDR_WIDTH
`define INSN_ADDR_WIDTH 32
`endif

module insn_fetch_unit #(
  parameter int                    INSN_WIDTH = `INSN_WIDTH,
  parameter int                    ADDR_WIDTH = `INSN_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  insn_fetch_unit_if.master        bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  infl_v;
  logic [ADDR_WIDTH-1:0] infl_pc;

  logic [ADDR_WIDTH-1:0] fifo_pc   [2];
  logic [INSN_WIDTH-1:0] fifo_insn [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occ;
  logic                  not_empty;

  // Stage 0: address issue. Reset forces RESET_PC onto the bus; a redirect
  // bypasses pc_q so the target is fetched in the same cycle.
  assign fetch_addr    = rst ? RESET_PC : (bus.redirect_valid ? bus.redirect_pc : pc_q);
  assign bus.imem_addr = fetch_addr;

  assign not_empty     = (count != 2'd0);
  assign bus.out_valid = not_empty & ~bus.redirect_valid;
  assign bus.out_pc    = not_empty ? fifo_pc[rd_ptr]   : '0;
  assign bus.out_insn  = not_empty ? fifo_insn[rd_ptr] : '0;

  assign pop  = bus.out_valid & ~bus.stall;
  assign push = infl_v & ~bus.redirect_valid;

  // Credit check: entries held after this cycle plus the one landing next
  // cycle must fit in the FIFO. A redirect flushes, so it always has room.
  assign occ   = {1'b0, count} + {2'b00, infl_v} - {2'b00, pop};
  assign issue = ~rst & (bus.redirect_valid | (occ < 3'd2));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      infl_v <= 1'b0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      infl_v <= issue;
      if (issue)
        pc_q <= fetch_addr + ADDR_WIDTH'(PC_STEP);
      if (bus.redirect_valid) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= ~wr_ptr;
        if (pop)
          rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Stage 1: memory response capture, tagged with the PC of the request
  // issued last cycle. Storage is data only; validity lives in count.
  always_ff @(posedge clk) begin
    if (issue)
      infl_pc <= fetch_addr;
    if (push) begin
      fifo_pc[wr_ptr]   <= infl_pc;
      fifo_insn[wr_ptr] <= bus.imem_insn;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (count == 2'd2)));

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.out_valid & bus.stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
`timescale 1ns/1ps
module tb_insn_fetch_unit;
  localparam int IW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  insn_fetch_unit_if #(.INSN_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  insn_fetch_unit #(
    .INSN_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .RESET_PC  ('0),
    .PC_STEP   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Synchronous-read memory: contents are a fixed function of the address.
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  logic [AW-1:0] mem_addr_q;
  always @(posedge clk) mem_addr_q <= bus.imem_addr;
  assign bus.imem_insn = memf(mem_addr_q);

  int total = 0;
  int bad = 0;
  int phase_pops = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every hand-off to decode is compared against the scoreboard.
  initial begin
    logic [AW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && !bus.stall) begin
        phase_pops++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %h expected no entry", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", bus.out_pc, e);
          check("out_insn", bus.out_insn, memf(e));
        end
      end
    end
  end

  // Stimulus; cycle numbers count from the first cycle with rst low.
  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_insn", bus.out_insn, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'd0);

    // Sequential stream from RESET_PC, with a 5-cycle stall from cycle 4.
    push_seq(32'h0, 5);
    tick(); rst = 1'b0; #1;                                   // cycle 0
    check("c0_addr", bus.imem_addr, 32'h0);
    check("c0_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;                                               // cycle 1
    check("c1_addr", bus.imem_addr, 32'h4);
    check("c1_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;                                               // cycle 2
    check("c2_valid", 32'(bus.out_valid), 32'd1);
    check("c2_pc", bus.out_pc, 32'h0);
    check("c2_addr", bus.imem_addr, 32'h8);
    tick(); #1;                                               // cycle 3
    check("c3_addr", bus.imem_addr, 32'hC);
    tick(); bus.stall = 1'b1; #1;                             // cycle 4
    check("c4_pc", bus.out_pc, 32'h8);
    check("c4_addr", bus.imem_addr, 32'h10);
    repeat (4) tick(); #1;                                    // cycle 8
    check("c8_valid", 32'(bus.out_valid), 32'd1);
    check("c8_pc_frozen", bus.out_pc, 32'h8);
    check("c8_addr_frozen", bus.imem_addr, 32'h10);
    tick(); bus.stall = 1'b0; #1;                             // cycle 9
    check("c9_addr", bus.imem_addr, 32'h10);
    tick(); tick(); tick(); bus.stall = 1'b1; #1;             // cycle 12
    check("c12_pc", bus.out_pc, 32'h14);
    tick(); #1;                                               // cycle 13
    check("c13_pc_full", bus.out_pc, 32'h14);

    // Redirect while stalled with a full FIFO.
    tick();                                                   // cycle 14
    check("phaseA_pops", phase_pops, 32'd5);
    phase_pops = 0; exp_q.delete(); push_seq(32'h100, 3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
    check("c14_valid_redirect", 32'(bus.out_valid), 32'd0);
    check("c14_addr_redirect", bus.imem_addr, 32'h100);
    tick(); bus.redirect_valid = 1'b0; bus.stall = 1'b0; #1;  // cycle 15
    check("c15_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;                                               // cycle 16
    check("c16_valid", 32'(bus.out_valid), 32'd1);
    check("c16_pc", bus.out_pc, 32'h100);
    tick(); tick();                                           // cycle 18

    // Back-to-back redirects: 0x40 then 0x80.
    tick();                                                   // cycle 19
    check("phaseB_pops", phase_pops, 32'd3);
    phase_pops = 0; exp_q.delete(); push_seq(32'h80, 3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; #1;
    check("c19_addr", bus.imem_addr, 32'h40);
    tick(); bus.redirect_pc = 32'h80; #1;                     // cycle 20
    check("c20_addr", bus.imem_addr, 32'h80);
    check("c20_valid", 32'(bus.out_valid), 32'd0);
    tick(); bus.redirect_valid = 1'b0; #1;                    // cycle 21
    check("c21_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;                                               // cycle 22
    check("c22_pc", bus.out_pc, 32'h80);
    tick(); tick();                                           // cycle 24
    tick(); bus.stall = 1'b1;                                 // cycle 25

    // One-cycle reset with a full FIFO.
    tick();                                                   // cycle 26
    check("phaseC_pops", phase_pops, 32'd3);
    phase_pops = 0; exp_q.delete(); push_seq(32'h0, 3);
    rst = 1'b1; #1;
    check("c26_rst_addr", bus.imem_addr, 32'h0);
    tick(); rst = 1'b0; bus.stall = 1'b0; #1;                 // cycle 27
    check("c27_valid", 32'(bus.out_valid), 32'd0);
    check("c27_addr", bus.imem_addr, 32'h0);
    repeat (4) tick();                                        // cycle 31

    // Redirect to the top of the address space; PC wraps to 0.
    tick();                                                   // cycle 32
    check("phaseD_pops", phase_pops, 32'd3);
    phase_pops = 0; exp_q.delete(); push_seq(32'hFFFF_FFFC, 3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
    tick(); bus.redirect_valid = 1'b0; #1;                    // cycle 33
    tick(); #1;                                               // cycle 34
    check("c34_pc", bus.out_pc, 32'hFFFF_FFFC);
    tick(); #1;                                               // cycle 35
    check("c35_pc_wrap", bus.out_pc, 32'h0);
    tick();                                                   // cycle 36
    tick(); bus.stall = 1'b1;                                 // cycle 37
    tick(); tick(); tick(); #1;                               // cycle 40
    check("phaseE_pops", phase_pops, 32'd3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef IFETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 32'd6);
    check("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
